inst_fetch: RTL
===============

# inst_fetch

Instruction fetch stage for the single-cycle-issue core. It sits directly upstream of the opcode decoder. It holds the program counter and fetches 32-bit instructions through a ready/request handshake with instruction memory. It latches each instruction and presents `opcode`/`subopcode` to the decoder, then updates the PC from the decoder's `branch_ena`/`Jump_ena` outputs.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset (word-aligned)
- `CNT_W`, 16, width of the retired-instruction counter

- `clk`  in  1  core clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `im_req`  out  1  instruction memory read request
- `im_addr`  out  32  byte address of requested instruction (= `pc`)
- `im_ready`  in  1  memory has valid data on `im_rdata` this cycle
- `im_rdata`  in  32  instruction word
- `stall`  in  1  hold current instruction in EXEC (downstream busy)
- `branch_ena`  in  1  from decoder: current instruction is BEQ
- `Jump_ena`  in  1  from decoder: current instruction is J
- `eq_flag`  in  1  register comparison result (read_data1 == read_data2)
- `target_off`  in  32  sign-extended byte offset, relative to `pc`
- `pc`  out  32  address of the instruction held in `inst`
- `inst`  out  32  latched instruction
- `opcode`  out  6  `inst[30:25]`
- `subopcode`  out  5  `inst[4:0]`
- `inst_valid`  out  1  `inst` is executing this cycle; downstream write enables are gated by it
- `retire_cnt`  out  CNT_W  instructions retired, wraps modulo 2^CNT_W

## Operation
- States: IDLE, FETCH, EXEC.
- Reset (`rst`=0, asynchronous):
  - state=IDLE, `pc`=RESET_PC, `inst`=0, `inst_valid`=0, `im_req`=0, `retire_cnt`=0.
  - Reset asserted mid-fetch or mid-EXEC aborts the cycle. No PC update, no count.
- IDLE: one cycle after reset release, then FETCH unconditionally.
- FETCH:
  - `im_req`=1, `im_addr`=`pc`, held stable until accepted.
  - On an edge with `im_ready`=1: `inst`<=`im_rdata`, go to EXEC.
  - Otherwise remain in FETCH indefinitely.
- EXEC:
  - `inst_valid`=1, `im_req`=0.
  - If `stall`=1: remain in EXEC. `pc`, `inst` and the counter are held, and `inst_valid` stays 1.
  - If `stall`=0, retire:
    - `retire_cnt`+1.
    - Next PC: if `Jump_ena`, `pc`+`target_off`; else if `branch_ena` and `eq_flag`, `pc`+`target_off`; else `pc`+4.
    - Go to FETCH.
- `Jump_ena` has priority over `branch_ena` when both are set.
- `branch_ena`/`Jump_ena`/`eq_flag`/`target_off` are sampled only on the retiring EXEC edge and are ignored in every other state.
- PC arithmetic is 32-bit unsigned, wrapping modulo 2^32. Bits [1:0] of the next PC are forced to 0.
- `opcode`/`subopcode` are combinational slices of `inst`. They hold the last instruction outside EXEC, so decoder outputs outside EXEC are don't-care.

## Timing
- Minimum 2 cycles per instruction: FETCH (with `im_ready`=1), then EXEC.
- Fetch latency = 1 + number of FETCH cycles with `im_ready`=0.
- `im_ready` is qualified only while `im_req`=1; `im_ready` pulses in IDLE/EXEC are ignored.
- The first `im_req` rises on the 2nd rising edge after `rst` deasserts (IDLE occupies 1 cycle).
- `inst_valid` rises on the edge that captures `im_ready` and falls on the retiring edge.
- Retirement effects (PC update, counter increment, state change) all occur on the same edge.

## Test plan
- Reset and sequential fetch: reset, then `im_ready`=1 always, memory returns ADD words.
  - `im_addr` = 0, 4, 8, 12 in successive FETCH cycles, `inst_valid` toggles 0/1.
  - `retire_cnt`=4 after 8 cycles.
- Wait states: `im_ready` low for 3 cycles at pc=8.
  - `im_req` stays 1 with `im_addr`=8 for 4 cycles, then `inst` captured.
  - No `retire_cnt` change during the wait.
- Branch: BEQ at pc=0x20 with `target_off`=0xFFFF_FFF0.
  - `eq_flag`=1 gives next `im_addr`=0x10.
  - `eq_flag`=0 gives 0x24.
  - `Jump_ena`+`branch_ena` with `eq_flag`=0 and `target_off`=0x40 gives 0x60.
- Stall and wrap:
  - `stall`=1 for 5 EXEC cycles: `pc`/`inst` held, `inst_valid`=1, counter frozen.
  - pc=0xFFFF_FFFC sequential gives next 0x0.
  - `retire_cnt` at 0xFFFF retires to 0x0000.
- Reset mid-operation: drop `rst` during FETCH with `im_ready`=0, and separately during stalled EXEC.
  - Outputs immediately return to reset values, with no clock edge required.
  - After release, the first fetch address is RESET_PC.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, fetches over a ready/request handshake,
// holds the instruction for the decoder and retires it with the next-PC update.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic             im_req,
    output logic [31:0]      im_addr,
    input  logic             im_ready,
    input  logic [31:0]      im_rdata,
    input  logic             stall,
    input  logic             branch_ena,
    input  logic             Jump_ena,
    input  logic             eq_flag,
    input  logic [31:0]      target_off,
    output logic [31:0]      pc,
    output logic [31:0]      inst,
    output logic [5:0]       opcode,
    output logic [4:0]       subopcode,
    output logic             inst_valid,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_started;
    logic [31:0]        r_pc;
    logic [31:0]        r_inst;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_capture;
    logic               w_retire;
    logic               w_take;
    logic [31:0]        w_sum;
    logic [31:0]        w_next_pc;

    assign w_capture = (r_state == FETCH) && im_ready;
    assign w_retire  = (r_state == EXEC) && !stall;

    // Jump wins over a taken branch; both use the same pc-relative offset.
    assign w_take    = Jump_ena | (branch_ena & eq_flag);
    assign w_sum     = r_pc + (w_take ? target_off : 32'd4);
    assign w_next_pc = {w_sum[31:2], 2'b00};

    // IDLE lasts one full cycle after the first edge following reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_started <= 1'b0;
        end else begin
            r_started <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (r_started) w_next_state = FETCH;
            FETCH:   if (im_ready)  w_next_state = EXEC;
            EXEC:    if (!stall)    w_next_state = FETCH;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc   <= RESET_PC;
            r_inst <= 32'd0;
            r_cnt  <= '0;
        end else begin
            if (w_capture) begin
                r_inst <= im_rdata;
            end
            if (w_retire) begin
                r_pc  <= w_next_pc;
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign im_req     = (r_state == FETCH);
    assign im_addr    = r_pc;
    assign inst_valid = (r_state == EXEC);
    assign pc         = r_pc;
    assign inst       = r_inst;
    assign opcode     = r_inst[30:25];
    assign subopcode  = r_inst[4:0];
    assign retire_cnt = r_cnt;

endmodule
